score_hex_display: RTL and testbench
====================================

// Module: score_hex_display
// PURPOSE
//   Score counter and HEX driver for the DE1-SoC snake game.
//   Counts apple-eaten pulses from the snake engine and converts the binary score to BCD with a sequential double-dabble FSM.
//   Drives HEX3..HEX0 with the decimal score and blanks HEX5/HEX4.
//   Sits beside vga_demo in top and replaces the constant HEX blanking.
// PARAMETERS
//   SCORE_W    14     score register width in bits; must hold MAX_SCORE
//   MAX_SCORE  9999   saturation value; 4 decimal digits
// PORTS
//   CLOCK_50   in   1        system clock (50 MHz)
//   resetn     in   1        asynchronous active-low reset (from KEY[0])
//   score_inc  in   1        1-cycle pulse: +1 point
//   score_clr  in   1        1-cycle pulse: new game, score := 0
//   score      out  SCORE_W  current binary score
//   busy       out  1        BCD conversion in progress
//   HEX0..HEX3 out  7 each   digits ones..thousands; active-low, bit0=a .. bit6=g
//   HEX4,HEX5  out  7 each   constant 7'h7F (off)
// BEHAVIOUR
// - Reset values (async, resetn=0): score=0, dirty=0, FSM=IDLE, busy=0, BCD display reg=0.
//   HEX3..HEX0 show "0000" = 7'h40 (blanking rules under CONFIGURATION); HEX5/HEX4 = 7'h7F.
//   Reset asserted mid-conversion aborts it immediately; no partial value reaches the HEX outputs.
// - Score register, per edge:
//   - score_clr=1: score := 0 (clr wins over a simultaneous inc).
//   - else score_inc=1 and score < MAX_SCORE: score := score+1.
//   - else score_inc=1 at MAX_SCORE: hold at MAX_SCORE, no wrap.
//   - dirty := 1 on any edge where score changes value or clr is applied.
// - FSM states IDLE, SHIFT, LATCH:
//   - IDLE & dirty: load sh = {16'b0, score}, cnt := SCORE_W, dirty := 0, -> SHIFT.
//   - SHIFT: each cycle, every BCD nibble >= 5 gets +3 (all nibbles in parallel, combinational), then sh <<= 1 and cnt--.
//     When cnt reaches 0, -> LATCH.
//   - LATCH: display reg := sh[SCORE_W+15:SCORE_W], -> IDLE.
//   - busy = (state != IDLE), registered with the state.
// - Score changes during SHIFT/LATCH set dirty; the conversion in flight completes, then a new one starts from IDLE.
//   The display always converges to the final score. No request is queued beyond one.
// - Latency: score changes at edge N, so the HEX outputs change at edge N+SCORE_W+2 (16 for the default).
//   busy is high for SCORE_W+1 cycles per conversion.
// - HEX outputs are combinational decode of the display reg only, so they are glitch-free between latches.
//   Active-low encoding, 0..9:
//     40 79 24 30 19 12 02 78 00 10
//   Nibble values > 9 cannot occur; decode them to 7'h7F.
// CONFIGURATION
// - `define LEADING_ZERO_BLANK_EN:
//   - Defined: HEX3..HEX1 show 7'h7F while the digit and all more-significant digits are 0.
//     HEX0 always shows its digit (score 0 -> "   0").
//   - Undefined: all four digits always shown, zero-padded ("0000").
// TESTING
// 1. resetn low 3 cycles, release -> HEX3..HEX0=7'h40 (or 7'h7F,7'h7F,7'h7F,7'h40 with _EN); HEX5/HEX4=7'h7F; score=0; busy=0.
// 2. One score_inc at edge N -> score=1 at N; busy=1 for 15 cycles; HEX0=7'h79 exactly at N+16.
// 3. 12 inc pulses spaced 20 cycles -> HEX1=7'h79, HEX0=7'h24, HEX3/HEX2=7'h40 (7'h7F with _EN); score=12.
// 4. 5 inc pulses on consecutive cycles during busy -> after settling, HEX0=7'h12 and busy=0; no intermediate value shows after the final latch.
// 5. 10005 inc pulses -> score=9999, all HEX3..HEX0=7'h10; a further inc leaves score=9999 and dirty=0.
// 6. score_clr+score_inc in the same cycle at score=7 -> score=0, display "0".
//    resetn pulsed low mid-SHIFT -> outputs are at reset values in the same cycle.

Source files
------------

// File: rtl/score_hex_display_if.sv
// Score/HEX bundle between the snake engine (master) and the score display block (slave).
// Carries the point pulses in, and the binary score, busy flag and six 7-segment drives out.
interface score_hex_display_if #(
  parameter int SCORE_W = 14
);
  logic               score_inc;
  logic               score_clr;
  logic [SCORE_W-1:0] score;
  logic               busy;
  logic [6:0]         HEX0;
  logic [6:0]         HEX1;
  logic [6:0]         HEX2;
  logic [6:0]         HEX3;
  logic [6:0]         HEX4;
  logic [6:0]         HEX5;

  modport master (
    output score_inc, score_clr,
    input  score, busy, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );

  modport slave (
    input  score_inc, score_clr,
    output score, busy, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );
endinterface

// File: rtl/score_hex_display.sv
// Saturating score counter with sequential double-dabble BCD conversion driving HEX3..HEX0.
// Latency: score change at edge N shows on the HEX outputs at edge N+SCORE_W+2; no backpressure, one pending refresh.
// Optional `LEADING_ZERO_BLANK_EN blanks leading zero digits on HEX3..HEX1.
module score_hex_display #(
  parameter int SCORE_W   = 14,
  parameter int MAX_SCORE = 9999
) (
  input  logic CLOCK_50,
  input  logic resetn,
  score_hex_display_if.slave sif
);

  localparam int CNT_W = $clog2(SCORE_W + 1);
  localparam int SH_W  = SCORE_W + 16;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t             state;
  logic               busy_q;
  logic               dirty;
  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W-1:0] score_nxt;
  logic               dirty_set;
  logic [SH_W-1:0]    sh;
  logic [SH_W-1:0]    sh_adj;
  logic [CNT_W-1:0]   cnt;
  logic [15:0]        disp;
  logic               blank3;
  logic               blank2;
  logic               blank1;

  function automatic logic [15:0] add3(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Clear wins over increment; increments at the ceiling are dropped.
  always_comb begin
    score_nxt = score_q;
    if (sif.score_clr) begin
      score_nxt = '0;
    end else if (sif.score_inc && (score_q < SCORE_W'(MAX_SCORE))) begin
      score_nxt = score_q + SCORE_W'(1);
    end
    dirty_set = sif.score_clr || (score_nxt != score_q);
    sh_adj    = {add3(sh[SH_W-1:SCORE_W]), sh[SCORE_W-1:0]};
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      busy_q  <= 1'b0;
      dirty   <= 1'b0;
      score_q <= '0;
      sh      <= '0;
      cnt     <= '0;
      disp    <= '0;
    end else begin
      score_q <= score_nxt;
      // A fresh change on the load edge must survive, so set beats clear.
      if (dirty_set) begin
        dirty <= 1'b1;
      end else if (state == IDLE && dirty) begin
        dirty <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (dirty) begin
            sh     <= {16'b0, score_q};
            cnt    <= CNT_W'(SCORE_W);
            state  <= SHIFT;
            busy_q <= 1'b1;
          end
        end
        SHIFT: begin
          sh  <= sh_adj << 1;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= LATCH;
        end
        LATCH: begin
          disp   <= sh[SH_W-1:SCORE_W];
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    blank3 = 1'b0;
    blank2 = 1'b0;
    blank1 = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    blank3 = (disp[15:12] == 4'd0);
    blank2 = blank3 && (disp[11:8] == 4'd0);
    blank1 = blank2 && (disp[7:4] == 4'd0);
`endif
  end

  assign sif.score = score_q;
  assign sif.busy  = busy_q;
  assign sif.HEX0  = seg7(disp[3:0]);
  assign sif.HEX1  = blank1 ? 7'h7F : seg7(disp[7:4]);
  assign sif.HEX2  = blank2 ? 7'h7F : seg7(disp[11:8]);
  assign sif.HEX3  = blank3 ? 7'h7F : seg7(disp[15:12]);
  assign sif.HEX4  = 7'h7F;
  assign sif.HEX5  = 7'h7F;

endmodule

// File: tb/tb_score_hex_display.sv
// Bench for score_hex_display: directed pulses, expected settled displays queued and checked by a monitor.
module tb_score_hex_display;

  typedef struct packed {
    logic [13:0] score;
    logic [27:0] hex;
  } exp_t;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif
  localparam logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic CLOCK_50 = 1'b0;
  logic resetn   = 1'b0;
  int   n_cmp    = 0;
  int   n_err    = 0;
  exp_t exp_q[$];

  score_hex_display_if #(.SCORE_W(14)) sif ();

  score_hex_display #(.SCORE_W(14), .MAX_SCORE(9999)) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .sif      (sif)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push(input int s, input logic [6:0] h3, input logic [6:0] h2,
                      input logic [6:0] h1, input logic [6:0] h0);
    exp_t e;
    e.score = 14'(s);
    e.hex   = {h3, h2, h1, h0};
    exp_q.push_back(e);
  endtask

  task automatic pulse(input logic inc, input logic clr);
    @(negedge CLOCK_50);
    sif.score_inc = inc;
    sif.score_clr = clr;
    @(negedge CLOCK_50);
    sif.score_inc = 1'b0;
    sif.score_clr = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() > 0 && t < 400) begin
      @(negedge CLOCK_50);
      t++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: %0d displays still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: a conversion counts as settled when busy stays low two cycles after falling.
  initial begin
    logic prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge CLOCK_50);
      if (prev && !sif.busy) begin
        repeat (2) @(negedge CLOCK_50);
        if (!sif.busy && resetn && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("sb_hex", 64'({sif.HEX3, sif.HEX2, sif.HEX1, sif.HEX0}), 64'(e.hex));
          check("sb_score", 64'(sif.score), 64'(e.score));
          check("sb_hex54", 64'({sif.HEX5, sif.HEX4}), 64'h3FFF);
        end
      end
      prev = sif.busy;
    end
  end

  initial begin
    int busy_cnt;
    int hex_k;
    sif.score_inc = 1'b0;
    sif.score_clr = 1'b0;

    // Reset state
    repeat (3) @(negedge CLOCK_50);
    resetn = 1'b1;
    @(negedge CLOCK_50);
    check("rst_score", 64'(sif.score), 64'd0);
    check("rst_busy", 64'(sif.busy), 64'd0);
    check("rst_hex", 64'({sif.HEX3, sif.HEX2, sif.HEX1, sif.HEX0}), 64'({LZ, LZ, LZ, 7'h40}));
    check("rst_hex54", 64'({sif.HEX5, sif.HEX4}), 64'h3FFF);

    // Single increment: exact busy length and display latency
    push(1, LZ, LZ, LZ, 7'h79);
    @(negedge CLOCK_50);
    sif.score_inc = 1'b1;
    @(posedge CLOCK_50);
    #1 sif.score_inc = 1'b0;
    check("lat_score", 64'(sif.score), 64'd1);
    busy_cnt = 0;
    hex_k    = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge CLOCK_50);
      #1;
      if (sif.busy) busy_cnt++;
      if (hex_k == 0 && sif.HEX0 == 7'h79) hex_k = k;
    end
    check("lat_busy_cycles", 64'(busy_cnt), 64'd15);
    check("lat_hex_edge", 64'(hex_k), 64'd16);
    drain("lat");

    // Spaced increments up to 12
    for (int s = 2; s <= 12; s++) begin
      push(s, LZ, LZ, (s >= 10) ? 7'h79 : LZ, SEG[s % 10]);
      pulse(1'b1, 1'b0);
      repeat (20) @(negedge CLOCK_50);
    end
    drain("spaced");

    // Clear, then five increments while the clear conversion is busy
    push(5, LZ, LZ, LZ, 7'h12);
    pulse(1'b0, 1'b1);
    repeat (2) @(negedge CLOCK_50);
    sif.score_inc = 1'b1;
    repeat (5) @(negedge CLOCK_50);
    sif.score_inc = 1'b0;
    drain("burst");
    repeat (30) @(negedge CLOCK_50);
    check("burst_stable_hex0", 64'(sif.HEX0), 64'h12);
    check("burst_busy", 64'(sif.busy), 64'd0);

    // Saturation at 9999
    push(9999, 7'h10, 7'h10, 7'h10, 7'h10);
    @(negedge CLOCK_50);
    sif.score_inc = 1'b1;
    repeat (10005) @(negedge CLOCK_50);
    sif.score_inc = 1'b0;
    drain("sat");
    pulse(1'b1, 1'b0);
    busy_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLOCK_50);
      if (sif.busy) busy_cnt++;
    end
    check("sat_hold_score", 64'(sif.score), 64'd9999);
    check("sat_no_refresh", 64'(busy_cnt), 64'd0);

    // Clear and increment together at score 7
    push(7, LZ, LZ, LZ, 7'h78);
    pulse(1'b0, 1'b1);
    @(negedge CLOCK_50);
    sif.score_inc = 1'b1;
    repeat (7) @(negedge CLOCK_50);
    sif.score_inc = 1'b0;
    drain("seven");
    push(0, LZ, LZ, LZ, 7'h40);
    pulse(1'b1, 1'b1);
    check("clr_wins_score", 64'(sif.score), 64'd0);
    drain("clr_inc");

    // Reset in the middle of a conversion
    push(1, LZ, LZ, LZ, 7'h79);
    pulse(1'b1, 1'b0);
    drain("pre_rst");
    pulse(1'b1, 1'b0);
    repeat (5) @(negedge CLOCK_50);
    #3 resetn = 1'b0;
    #1;
    check("mid_rst_score", 64'(sif.score), 64'd0);
    check("mid_rst_busy", 64'(sif.busy), 64'd0);
    check("mid_rst_hex", 64'({sif.HEX3, sif.HEX2, sif.HEX1, sif.HEX0}), 64'({LZ, LZ, LZ, 7'h40}));
    repeat (3) @(negedge CLOCK_50);
    resetn = 1'b1;
    repeat (20) @(negedge CLOCK_50);
    check("post_rst_busy", 64'(sif.busy), 64'd0);
    check("post_rst_hex0", 64'(sif.HEX0), 64'h40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
